// File: rtl/park_gate_if.sv
// ---------------------------------------------------------------------------
// park_gate_if
//   Bundle between the parking access controller / lane sensors and the
//   barrier sequencer (park_gate).
//
//   Controller / lane side (master modport drives):
//     BS          entry grant pulse from the access controller
//     ent_sns     entry loop sensor, high while a vehicle is under the barrier
//     ext_req     exit request pulse
//     ext_sns     exit loop sensor, high while a vehicle is under the barrier
//   Sequencer side (slave modport drives):
//     gate_in     barrier open for entry
//     gate_out    barrier open for exit
//     occ         current lot occupancy
//     full        occ == CAP
//     grant_lost  one-cycle pulse, a BS grant was dropped
//     tmo         one-cycle pulse, barrier opened but no vehicle passed
// ---------------------------------------------------------------------------
interface park_gate_if #(
  parameter int CAP = 8
);
  localparam int OCC_W = $clog2(CAP + 1);

  logic             BS;
  logic             ent_sns;
  logic             ext_req;
  logic             ext_sns;
  logic             gate_in;
  logic             gate_out;
  logic [OCC_W-1:0] occ;
  logic             full;
  logic             grant_lost;
  logic             tmo;

  modport master (
    output BS, ent_sns, ext_req, ext_sns,
    input  gate_in, gate_out, occ, full, grant_lost, tmo
  );

  modport slave (
    input  BS, ent_sns, ext_req, ext_sns,
    output gate_in, gate_out, occ, full, grant_lost, tmo
  );
endinterface

// File: rtl/park_gate.sv
// ---------------------------------------------------------------------------
// park_gate
//   Barrier sequencer sitting behind the parking access controller. A single
//   shared barrier is driven through open / vehicle-pass / close phases for
//   either an entry (triggered by the BS grant pulse) or an exit (triggered
//   by a latched exit request). Lot occupancy is tracked, and the block
//   reports full, timeout and dropped-grant conditions.
//
//   Parameters:
//     CAP        lot capacity in vehicles
//     OPEN_CYC   cycles the open barrier waits for a vehicle before timing out
//     CLOSE_CYC  barrier travel time in cycles (barrier busy meanwhile)
//
//   Ports:
//     clk        system clock, rising edge
//     reset      asynchronous, active-low reset
//     bus        park_gate_if.slave: BS, ent_sns, ext_req, ext_sns in;
//                gate_in, gate_out, occ, full, grant_lost, tmo out
// ---------------------------------------------------------------------------
module park_gate #(
  parameter int CAP       = 8,
  parameter int OPEN_CYC  = 10,
  parameter int CLOSE_CYC = 3
) (
  input  logic       clk,
  input  logic       reset,
  park_gate_if.slave bus
);

  localparam int OCC_W   = $clog2(CAP + 1);
  localparam int TMR_MAX = (OPEN_CYC > CLOSE_CYC) ? OPEN_CYC : CLOSE_CYC;
  // The timer only ever holds 0 .. TMR_MAX-1.
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(OPEN_CYC - 1);
  localparam logic [TMR_W-1:0] CLOSE_LAST = TMR_W'(CLOSE_CYC - 1);
  localparam logic [OCC_W-1:0] OCC_CAP    = OCC_W'(CAP);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IN_OPEN,
    ST_IN_PASS,
    ST_OUT_OPEN,
    ST_OUT_PASS,
    ST_CLOSING
  } state_t;

  state_t           state_q;
  logic [TMR_W-1:0] tmr_q;
  logic [OCC_W-1:0] occ_q;
  logic             ext_pend_q;
  logic             ext_pend_d;
  logic             gate_in_q;
  logic             gate_out_q;
  logic             grant_lost_q;
  logic             tmo_q;

  logic             lot_full;
  logic             lot_empty;
  logic             entry_active;
  logic             start_exit;

  assign lot_full     = (occ_q == OCC_CAP);
  assign lot_empty    = (occ_q == '0);
  assign entry_active = (state_q == ST_IN_OPEN) || (state_q == ST_IN_PASS);

  // An entry grant always takes priority over a pending exit in IDLE, even
  // when that grant is dropped because the lot is full.
  assign start_exit   = (state_q == ST_IDLE) && !bus.BS && ext_pend_q && !lot_empty;

  // Exit requests are only worth remembering if a vehicle is (or is about to
  // be) inside the lot. Starting the exit consumes the request; a request
  // arriving on that very cycle is treated as part of the one being served.
  always_comb begin
    ext_pend_d = ext_pend_q;
    if (start_exit) begin
      ext_pend_d = 1'b0;
    end else if (bus.ext_req && (!lot_empty || entry_active)) begin
      ext_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_pend_q <= 1'b0;
    end else begin
      ext_pend_q <= ext_pend_d;
    end
  end

  // Barrier sequencer. Gate outputs are registered alongside the state so
  // they change on exactly the same edge as the state that implies them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      occ_q        <= '0;
      gate_in_q    <= 1'b0;
      gate_out_q   <= 1'b0;
      grant_lost_q <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      grant_lost_q <= 1'b0;
      tmo_q        <= 1'b0;

      // Grants are never queued: outside IDLE, or with the lot full, they
      // are dropped and reported.
      if (bus.BS && ((state_q != ST_IDLE) || lot_full)) begin
        grant_lost_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (bus.BS) begin
            if (!lot_full) begin
              state_q   <= ST_IN_OPEN;
              tmr_q     <= '0;
              gate_in_q <= 1'b1;
            end
          end else if (start_exit) begin
            state_q    <= ST_OUT_OPEN;
            tmr_q      <= '0;
            gate_out_q <= 1'b1;
          end
        end

        ST_IN_OPEN: begin
          if (bus.ent_sns) begin
            state_q <= ST_IN_PASS;
          end else if (tmr_q == OPEN_LAST) begin
            tmo_q     <= 1'b1;
            gate_in_q <= 1'b0;
            state_q   <= ST_CLOSING;
            tmr_q     <= '0;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end

        // Once a vehicle is on the loop it is waited for indefinitely; the
        // barrier must not come down on it.
        ST_IN_PASS: begin
          if (!bus.ent_sns) begin
            occ_q     <= occ_q + 1'b1;
            gate_in_q <= 1'b0;
            state_q   <= ST_CLOSING;
            tmr_q     <= '0;
          end
        end

        ST_OUT_OPEN: begin
          if (bus.ext_sns) begin
            state_q <= ST_OUT_PASS;
          end else if (tmr_q == OPEN_LAST) begin
            tmo_q      <= 1'b1;
            gate_out_q <= 1'b0;
            state_q    <= ST_CLOSING;
            tmr_q      <= '0;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end

        ST_OUT_PASS: begin
          if (!bus.ext_sns) begin
            occ_q      <= occ_q - 1'b1;
            gate_out_q <= 1'b0;
            state_q    <= ST_CLOSING;
            tmr_q      <= '0;
          end
        end

        ST_CLOSING: begin
          if (tmr_q == CLOSE_LAST) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          tmr_q      <= '0;
          gate_in_q  <= 1'b0;
          gate_out_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gate_in    = gate_in_q;
  assign bus.gate_out   = gate_out_q;
  assign bus.occ        = occ_q;
  assign bus.full       = lot_full;
  assign bus.grant_lost = grant_lost_q;
  assign bus.tmo        = tmo_q;

endmodule

// File: tb/tb_park_gate.sv
module tb_park_gate;

  localparam int CAP       = 8;
  localparam int OPEN_CYC  = 10;
  localparam int CLOSE_CYC = 3;
  localparam int OCC_W     = $clog2(CAP + 1);

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int checks = 0;
  int errors = 0;

  park_gate_if #(.CAP(CAP)) bus ();

  park_gate #(
    .CAP       (CAP),
    .OPEN_CYC  (OPEN_CYC),
    .CLOSE_CYC (CLOSE_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Reference model: the barrier is described by which lane it serves
  // (0 none, 1 entry, 2 exit), whether a vehicle has been seen on the loop,
  // how many cycles it has waited open, and how many travel cycles remain.
  // -------------------------------------------------------------------------
  int m_dir;
  bit m_passing;
  int m_open;
  int m_down;
  bit m_pend;
  int m_occ;
  bit m_lost;
  bit m_tmo;

  task automatic model_reset();
    m_dir = 0; m_passing = 0; m_open = 0; m_down = 0;
    m_pend = 0; m_occ = 0; m_lost = 0; m_tmo = 0;
  endtask

  // v = {BS, ent_sns, ext_req, ext_sns} as seen at one rising edge
  task automatic model_step(input logic [3:0] v);
    bit bs, es, xr, xs, idle, start_out, pend_n, sns;
    bs = v[3]; es = v[2]; xr = v[1]; xs = v[0];
    idle      = (m_dir == 0) && (m_down == 0);
    start_out = idle && !bs && m_pend && (m_occ > 0);
    if (start_out) pend_n = 0;
    else if (xr && (m_occ > 0 || m_dir == 1)) pend_n = 1;
    else pend_n = m_pend;
    m_lost = bs && (!idle || m_occ == CAP);
    m_tmo  = 0;
    if (m_down > 0) begin
      m_down--;
    end else if (m_dir == 0) begin
      if (bs && m_occ < CAP) begin
        m_dir = 1; m_open = 0; m_passing = 0;
      end else if (start_out) begin
        m_dir = 2; m_open = 0; m_passing = 0;
      end
    end else begin
      sns = (m_dir == 1) ? es : xs;
      if (!m_passing) begin
        if (sns) begin
          m_passing = 1;
        end else begin
          m_open++;
          if (m_open == OPEN_CYC) begin
            m_tmo = 1; m_dir = 0; m_down = CLOSE_CYC;
          end
        end
      end else if (!sns) begin
        m_occ  = m_occ + ((m_dir == 1) ? 1 : -1);
        m_dir  = 0;
        m_down = CLOSE_CYC;
      end
    end
    m_pend = pend_n;
  endtask

  // Drive one cycle of inputs (away from the edge), advance the model, and
  // return #1 after the rising edge so outputs can be sampled.
  task automatic cycle(input logic [3:0] v);
    @(negedge clk);
    bus.BS = v[3]; bus.ent_sns = v[2]; bus.ext_req = v[1]; bus.ext_sns = v[0];
    model_step(v);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(4'b0000);
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    $display("test_reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.gate_in !== 1'b0) begin errors++; $display("FAIL reset_gate_in: got %b want 0", bus.gate_in); end
    checks++; if (bus.gate_out !== 1'b0) begin errors++; $display("FAIL reset_gate_out: got %b want 0", bus.gate_out); end
    checks++; if (bus.occ !== '0) begin errors++; $display("FAIL reset_occ: got %0d want 0", bus.occ); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
    checks++; if (bus.grant_lost !== 1'b0) begin errors++; $display("FAIL reset_grant_lost: got %b want 0", bus.grant_lost); end
    checks++; if (bus.tmo !== 1'b0) begin errors++; $display("FAIL reset_tmo: got %b want 0", bus.tmo); end
    reset = 1'b1;
    model_reset();
    cycle(4'b0000);
    checks++; if (bus.gate_in !== 1'b0 || bus.occ !== '0) begin errors++; $display("FAIL post_reset_idle: gate_in=%b occ=%0d want 0/0", bus.gate_in, bus.occ); end
  endtask

  task automatic test_empty_exit();
    $display("test_empty_exit");
    cycle(4'b0010);
    for (int i = 0; i < 4; i++) begin
      cycle(4'b0000);
      checks++; if (bus.gate_out !== 1'b0) begin errors++; $display("FAIL empty_exit_gate_out: cycle %0d got %b want 0", i, bus.gate_out); end
    end
  endtask

  task automatic test_normal_entry();
    logic [3:0] pat [5];
    int opened, occ0;
    $display("test_normal_entry");
    pat = '{4'b1000, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
    occ0 = m_occ;
    opened = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(pat[i]);
      if (i < 4) opened += int'(bus.gate_in);
    end
    checks++; if (opened != 4) begin errors++; $display("FAIL entry_open_cycles: got %0d want 4", opened); end
    checks++; if (bus.gate_in !== 1'b0) begin errors++; $display("FAIL entry_gate_drop: got %b want 0", bus.gate_in); end
    checks++; if (bus.occ !== OCC_W'(occ0 + 1)) begin errors++; $display("FAIL entry_occ: got %0d want %0d", bus.occ, occ0 + 1); end
    // Closing occupies the next three edges: a grant on the third is lost,
    // a grant on the fourth is accepted.
    idle_cycles(2);
    cycle(4'b1000);
    checks++; if (bus.grant_lost !== 1'b1 || bus.gate_in !== 1'b0) begin errors++; $display("FAIL closing_busy: grant_lost=%b gate_in=%b want 1/0", bus.grant_lost, bus.gate_in); end
    cycle(4'b1000);
    checks++; if (bus.gate_in !== 1'b1 || bus.grant_lost !== 1'b0) begin errors++; $display("FAIL idle_after_close: gate_in=%b grant_lost=%b want 1/0", bus.gate_in, bus.grant_lost); end
    cycle(4'b0100);
    cycle(4'b0000);
    checks++; if (bus.occ !== OCC_W'(occ0 + 2)) begin errors++; $display("FAIL entry2_occ: got %0d want %0d", bus.occ, occ0 + 2); end
    idle_cycles(3);
  endtask

  task automatic test_timeout();
    int occ0;
    $display("test_timeout");
    occ0 = m_occ;
    cycle(4'b1000);
    checks++; if (bus.gate_in !== 1'b1) begin errors++; $display("FAIL tmo_gate_open: got %b want 1", bus.gate_in); end
    for (int i = 1; i <= OPEN_CYC; i++) begin
      cycle(4'b0000);
      if (i < OPEN_CYC) begin
        checks++; if (bus.tmo !== 1'b0 || bus.gate_in !== 1'b1) begin errors++; $display("FAIL tmo_early: cycle %0d tmo=%b gate_in=%b want 0/1", i, bus.tmo, bus.gate_in); end
      end else begin
        checks++; if (bus.tmo !== 1'b1 || bus.gate_in !== 1'b0) begin errors++; $display("FAIL tmo_pulse: tmo=%b gate_in=%b want 1/0", bus.tmo, bus.gate_in); end
      end
    end
    checks++; if (bus.occ !== OCC_W'(occ0)) begin errors++; $display("FAIL tmo_occ: got %0d want %0d", bus.occ, occ0); end
    cycle(4'b0000);
    checks++; if (bus.tmo !== 1'b0) begin errors++; $display("FAIL tmo_one_cycle: got %b want 0", bus.tmo); end
    idle_cycles(2);
  endtask

  task automatic test_exit_queued();
    int occ0;
    $display("test_exit_queued");
    occ0 = m_occ;
    cycle(4'b1000);
    cycle(4'b0100);
    cycle(4'b0110);          // exit request while the entry vehicle is passing
    cycle(4'b0000);
    checks++; if (bus.occ !== OCC_W'(occ0 + 1)) begin errors++; $display("FAIL queued_entry_occ: got %0d want %0d", bus.occ, occ0 + 1); end
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0000);
      checks++; if (bus.gate_out !== 1'b0) begin errors++; $display("FAIL queued_early_open: cycle %0d gate_out=%b want 0", i, bus.gate_out); end
    end
    cycle(4'b0000);
    checks++; if (bus.gate_out !== 1'b1) begin errors++; $display("FAIL queued_open: gate_out=%b want 1", bus.gate_out); end
    cycle(4'b0001);
    cycle(4'b0000);
    checks++; if (bus.occ !== OCC_W'(occ0) || bus.gate_out !== 1'b0) begin errors++; $display("FAIL queued_exit_done: occ=%0d gate_out=%b want %0d/0", bus.occ, bus.gate_out, occ0); end
    idle_cycles(3);
  endtask

  task automatic test_collision();
    int occ0;
    $display("test_collision");
    occ0 = m_occ;
    cycle(4'b1010);
    checks++; if (bus.gate_in !== 1'b1 || bus.gate_out !== 1'b0) begin errors++; $display("FAIL collide_bs_wins: gate_in=%b gate_out=%b want 1/0", bus.gate_in, bus.gate_out); end
    cycle(4'b0100);
    cycle(4'b0000);
    idle_cycles(3);
    cycle(4'b0000);
    checks++; if (bus.gate_out !== 1'b1 || bus.occ !== OCC_W'(occ0 + 1)) begin errors++; $display("FAIL collide_exit_follows: gate_out=%b occ=%0d want 1/%0d", bus.gate_out, bus.occ, occ0 + 1); end
    cycle(4'b0001);
    cycle(4'b0000);
    checks++; if (bus.occ !== OCC_W'(occ0)) begin errors++; $display("FAIL collide_exit_occ: got %0d want %0d", bus.occ, occ0); end
    idle_cycles(3);
  endtask

  task automatic test_full();
    $display("test_full");
    for (int i = 0; i < CAP && m_occ < CAP; i++) begin
      checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL full_early: occ=%0d full=%b want 0", bus.occ, bus.full); end
      cycle(4'b1000);
      cycle(4'b0100);
      cycle(4'b0000);
      idle_cycles(3);
    end
    checks++; if (bus.full !== 1'b1 || bus.occ !== OCC_W'(CAP)) begin errors++; $display("FAIL full_set: full=%b occ=%0d want 1/%0d", bus.full, bus.occ, CAP); end
    cycle(4'b1000);
    checks++; if (bus.grant_lost !== 1'b1 || bus.gate_in !== 1'b0) begin errors++; $display("FAIL full_grant: grant_lost=%b gate_in=%b want 1/0", bus.grant_lost, bus.gate_in); end
    checks++; if (bus.occ !== OCC_W'(CAP)) begin errors++; $display("FAIL full_occ: got %0d want %0d", bus.occ, CAP); end
    cycle(4'b0000);
    checks++; if (bus.grant_lost !== 1'b0) begin errors++; $display("FAIL grant_lost_pulse: got %b want 0", bus.grant_lost); end
  endtask

  task automatic test_reset_mid();
    $display("test_reset_mid");
    cycle(4'b0010);
    cycle(4'b0000);
    checks++; if (bus.gate_out !== 1'b1) begin errors++; $display("FAIL mid_exit_open: got %b want 1", bus.gate_out); end
    cycle(4'b0001);
    cycle(4'b0000);
    idle_cycles(3);
    cycle(4'b1000);
    cycle(4'b0100);
    checks++; if (bus.gate_in !== 1'b1 || bus.occ !== OCC_W'(CAP - 1)) begin errors++; $display("FAIL mid_pass_setup: gate_in=%b occ=%0d want 1/%0d", bus.gate_in, bus.occ, CAP - 1); end
    #2;
    reset = 1'b0;
    bus.BS = 1'b0; bus.ent_sns = 1'b0; bus.ext_req = 1'b0; bus.ext_sns = 1'b0;
    #1;
    checks++; if (bus.gate_in !== 1'b0 || bus.occ !== '0 || bus.full !== 1'b0) begin errors++; $display("FAIL async_reset: gate_in=%b occ=%0d full=%b want 0/0/0", bus.gate_in, bus.occ, bus.full); end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    test_normal_entry();
  endtask

  task automatic test_random();
    logic [3:0] v;
    int occ_prev;
    $display("test_random");
    for (int n = 0; n < 2000; n++) begin
      v[3] = ($urandom_range(0, 99) < 15);
      v[2] = ($urandom_range(0, 99) < 40);
      v[1] = ($urandom_range(0, 99) < 10);
      v[0] = ($urandom_range(0, 99) < 40);
      occ_prev = m_occ;
      cycle(v);
      checks++; if (bus.gate_in !== 1'(m_dir == 1)) begin errors++; $display("FAIL rnd_gate_in: cyc %0d got %b want %b", n, bus.gate_in, m_dir == 1); end
      checks++; if (bus.gate_out !== 1'(m_dir == 2)) begin errors++; $display("FAIL rnd_gate_out: cyc %0d got %b want %b", n, bus.gate_out, m_dir == 2); end
      checks++; if (bus.occ !== OCC_W'(m_occ)) begin errors++; $display("FAIL rnd_occ: cyc %0d got %0d want %0d", n, bus.occ, m_occ); end
      checks++; if (bus.full !== 1'(m_occ == CAP)) begin errors++; $display("FAIL rnd_full: cyc %0d got %b want %b", n, bus.full, m_occ == CAP); end
      checks++; if (bus.grant_lost !== m_lost) begin errors++; $display("FAIL rnd_grant_lost: cyc %0d got %b want %b", n, bus.grant_lost, m_lost); end
      checks++; if (bus.tmo !== m_tmo) begin errors++; $display("FAIL rnd_tmo: cyc %0d got %b want %b", n, bus.tmo, m_tmo); end
      if (m_lost || m_tmo || m_occ != occ_prev)
        $display("txn cyc=%0d lost=%0b tmo=%0b occ=%0d", n, m_lost, m_tmo, m_occ);
    end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    bus.BS = 1'b0; bus.ent_sns = 1'b0; bus.ext_req = 1'b0; bus.ext_sns = 1'b0;
    model_reset();
    test_reset();
    test_empty_exit();
    test_normal_entry();
    test_timeout();
    test_exit_queued();
    test_collision();
    test_full();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/park_gate.md
# park_gate

Barrier sequencer downstream of the parking access controller. It takes the controller's one-cycle grant pulse `BS` and exit-lane requests, and drives a single shared barrier through open, vehicle-pass and close phases using loop-sensor feedback. It maintains lot occupancy, flags full and timeout conditions, and reports grants that could not be serviced.

## Interface
Parameters:
- `CAP`, 8: lot capacity (vehicles).
- `OPEN_CYC`, 10: cycles the barrier waits, open, for a vehicle before timing out.
- `CLOSE_CYC`, 3: barrier travel time in cycles, during which the barrier is busy.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `BS`  in  1  entry grant pulse from the access controller.
- `ent_sns`  in  1  entry loop sensor, high while a vehicle is under the barrier.
- `ext_req`  in  1  exit request pulse.
- `ext_sns`  in  1  exit loop sensor, high while a vehicle is under the barrier.
- `gate_in`  out  1  barrier open for entry.
- `gate_out`  out  1  barrier open for exit.
- `occ`  out  $clog2(CAP+1)  current occupancy.
- `full`  out  1  `occ == CAP`.
- `grant_lost`  out  1  one-cycle pulse: a `BS` grant was dropped.
- `tmo`  out  1  one-cycle pulse: the barrier opened but no vehicle passed.

## Operation
FSM states are IDLE, IN_OPEN, IN_PASS, OUT_OPEN, OUT_PASS and CLOSING. A timer `tmr` is wide enough for max(`OPEN_CYC`, `CLOSE_CYC`).

**Exit pending flag `ext_pend`:**
- Set by `ext_req` in any state, but only when `occ > 0` or an entry is in progress.
- Cleared on entering OUT_OPEN.
- When `occ == 0` and no entry is in progress, `ext_req` is ignored.

**IDLE:**
- If `BS` and `!full`: go to IN_OPEN, `tmr` = 0.
- If `BS` and `full`: pulse `grant_lost`, stay in IDLE.
- Else if `ext_pend` and `occ > 0`: go to OUT_OPEN, `tmr` = 0.
- If `BS` and `ext_req`/`ext_pend` are both present, `BS` wins and the exit stays pending.

**IN_OPEN:**
- If `ent_sns` = 1: go to IN_PASS.
- Else if `tmr == OPEN_CYC-1`: pulse `tmo`, go to CLOSING, `occ` unchanged.
- Else increment `tmr`.

**IN_PASS:**
- If `ent_sns` = 0: `occ` <= `occ` + 1, go to CLOSING.
- No timeout in this state.

**OUT_OPEN / OUT_PASS:**
- Same as IN_OPEN / IN_PASS, but using `ext_sns` and `occ` <= `occ` − 1.

**CLOSING:**
- Barrier is down.
- Count `CLOSE_CYC` cycles (`tmr` from 0 to `CLOSE_CYC`-1), then go to IDLE.

**Busy grants:** `BS` arriving in any state other than IDLE pulses `grant_lost` and is not queued.

**Occupancy bounds:**
- `occ` never exceeds `CAP`, because entry only starts when `!full`.
- `occ` never goes below 0, because exit only starts when `occ > 0`.
- There is no wrap-around.

**Outputs:**
- `gate_in` = state is IN_OPEN or IN_PASS.
- `gate_out` = state is OUT_OPEN or OUT_PASS.
- `full` is decoded from the `occ` register.
- `grant_lost` and `tmo` are registered pulses.

**Reset:**
- Asserting `reset` (low) at any time, including mid-pass, immediately forces the following, without waiting for a clock:
  - state = IDLE;
  - `tmr`, `occ` and `ext_pend` = 0;
  - all outputs = 0.
- The occupancy count is lost on reset; this is intended.

## Timing
- `BS` sampled at rising edge k (IDLE, not full): `gate_in` = 1 from edge k, i.e. visible in cycle k+1.
- `ent_sns` falling seen at edge m: at edge m, `occ` updates, `gate_in` drops to 0, and the FSM enters CLOSING. IDLE is reached at edge m+`CLOSE_CYC`.
- Timeout: with no sensor activity, `tmo` pulses `OPEN_CYC` cycles after entering IN_OPEN or OUT_OPEN, at the same edge the gate drops.
- `grant_lost` is high for exactly the one cycle following the edge that sampled the dropped `BS`.
- A pending exit is serviced on the first IDLE cycle that has no concurrent `BS`.
- All sequential logic is on the rising edge of `clk`. The only asynchronous element is reset.

## Test plan
1. **Normal entry.** Release reset, pulse `BS`, hold `ent_sns` high for 2 cycles starting 2 cycles later.
   - Expect: `gate_in` high for 4 cycles, then `occ` 0→1, then 3 CLOSING cycles, then IDLE.
2. **Entry timeout.** Pulse `BS` with `ent_sns` held at 0.
   - Expect: `tmo` pulses once, 10 cycles after the gate opens; `gate_in` falls on the same edge; `occ` unchanged.
3. **Full lot.** Complete 8 entries.
   - Expect: `full` = 1.
   - Then pulse `BS`: `grant_lost` pulses, `gate_in` stays 0, `occ` = 8.
4. **Exit queued behind entry.** Pulse `ext_req` while in IN_PASS.
   - Expect: after the entry's CLOSING completes, `gate_out` opens.
   - Then pulse `ext_sns`: `occ` decrements.
5. **Collisions and empty lot.**
   - `ext_req` with `occ` = 0 and no entry in progress: ignored, `gate_out` stays 0.
   - `BS` and `ext_req` in the same IDLE cycle: entry proceeds first, exit follows.
6. **Reset mid-operation.** Drive `reset` low mid IN_PASS, between clock edges.
   - Expect: `gate_in`, `occ` and `full` go to 0 immediately.
   - After release, behaviour is the same as scenario 1.
